// File: rtl/algorithm_range_src.sv
// Pull-driven list source: emits start, start+step, ... for count elements, then the
// all-ones nil marker, one registered response per consumer request.
module algorithm_range_src #(
  parameter int INT_N = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             args_valid,
  output logic             args_ready,
  input  logic [INT_N-1:0] start_in,
  input  logic [INT_N-1:0] step_in,
  input  logic [INT_N-1:0] count_in,
  input  logic             lst_req,
  output logic             lst_valid,
  output logic [INT_N-1:0] lst_data,
  output logic             busy,
  output logic             trunc
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [INT_N-1:0] NIL = '1;
  localparam logic [INT_N-1:0] ONE = INT_N'(1);

  state_t           state, state_nx;
  logic [INT_N-1:0] cur, step_r, remain;
  logic [INT_N-1:0] cur_nx, step_nx, remain_nx, data_nx;
  logic             valid_nx, trunc_nx;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur       <= '0;
      step_r    <= '0;
      remain    <= '0;
      lst_valid <= 1'b0;
      lst_data  <= '0;
      trunc     <= 1'b0;
    end else begin
      cur       <= cur_nx;
      step_r    <= step_nx;
      remain    <= remain_nx;
      lst_valid <= valid_nx;
      lst_data  <= data_nx;
      trunc     <= trunc_nx;
    end
  end

  // Exhausted count takes priority over the reserved-value check, so a stream
  // that ends exactly on all-ones is a clean end rather than a truncation.
  always_comb begin
    state_nx  = state;
    cur_nx    = cur;
    step_nx   = step_r;
    remain_nx = remain;
    data_nx   = lst_data;
    valid_nx  = 1'b0;
    trunc_nx  = trunc;
    case (state)
      IDLE: begin
        if (args_valid) begin
          cur_nx    = start_in;
          step_nx   = step_in;
          remain_nx = count_in;
          trunc_nx  = 1'b0;
          state_nx  = RUN;
        end
      end
      RUN: begin
        if (lst_req) begin
          valid_nx = 1'b1;
          if (remain == '0) begin
            data_nx  = NIL;
            state_nx = IDLE;
          end else if (cur == NIL) begin
            data_nx  = NIL;
            trunc_nx = 1'b1;
            state_nx = IDLE;
          end else begin
            data_nx   = cur;
            cur_nx    = cur + step_r;
            remain_nx = remain - ONE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign args_ready = (state == IDLE);
  assign busy       = (state == RUN);

endmodule

// File: tb/tb_algorithm_range_src.sv
// Bench for algorithm_range_src: directed scenarios followed by random traffic, all
// compared against a closed-form model (element i = start + i*step).
module tb_algorithm_range_src;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        args_valid;
  logic        args_ready;
  logic [31:0] start_in, step_in, count_in;
  logic        lst_req;
  logic        lst_valid;
  logic [31:0] lst_data;
  logic        busy;
  logic        trunc;

  int tests  = 0;
  int failed = 0;

  // Reference model state: the stream is described by its arguments and the
  // index of the next element, not by a running accumulator.
  logic        m_busy, m_valid, m_trunc;
  logic [31:0] m_start, m_step, m_count, m_idx, m_data;

  algorithm_range_src #(.INT_N(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .args_valid (args_valid),
    .args_ready (args_ready),
    .start_in   (start_in),
    .step_in    (step_in),
    .count_in   (count_in),
    .lst_req    (lst_req),
    .lst_valid  (lst_valid),
    .lst_data   (lst_data),
    .busy       (busy),
    .trunc      (trunc)
  );

  always #5 clk = ~clk;

  task automatic modelEdge(input logic rn, input logic av, input logic req,
                           input logic [31:0] s, input logic [31:0] st, input logic [31:0] c);
    logic [31:0] v;
    if (!rn) begin
      m_busy = 0; m_valid = 0; m_trunc = 0; m_data = 0;
      m_start = 0; m_step = 0; m_count = 0; m_idx = 0;
      return;
    end
    m_valid = 0;
    if (!m_busy) begin
      if (av) begin
        m_start = s; m_step = st; m_count = c; m_idx = 0;
        m_trunc = 0; m_busy = 1;
      end
    end else if (req) begin
      m_valid = 1;
      if (m_idx == m_count) begin
        m_data = 32'hFFFF_FFFF;
        m_busy = 0;
      end else begin
        v = m_start + m_idx * m_step;
        if (v == 32'hFFFF_FFFF) begin
          m_data  = 32'hFFFF_FFFF;
          m_trunc = 1;
          m_busy  = 0;
        end else begin
          m_data = v;
          m_idx  = m_idx + 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    chk("lst_valid",  {31'b0, lst_valid},  {31'b0, m_valid});
    chk("lst_data",   lst_data,            m_data);
    chk("args_ready", {31'b0, args_ready}, {31'b0, ~m_busy});
    chk("busy",       {31'b0, busy},       {31'b0, m_busy});
    chk("trunc",      {31'b0, trunc},      {31'b0, m_trunc});
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare just after it.
  task automatic applyStimulus(input logic rn, input logic av, input logic req,
                               input logic [31:0] s, input logic [31:0] st, input logic [31:0] c);
    rst_n = rn; args_valid = av; lst_req = req;
    start_in = s; step_in = st; count_in = c;
    @(posedge clk);
    modelEdge(rn, av, req, s, st, c);
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] s, st, c;
    logic        rn, av, req;

    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 7, 1, 3);
    idle(1);

    // Contiguous stream 3,4,5,6,nil with request held high
    applyStimulus(1, 1, 0, 3, 1, 4);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0, 0);
    idle(1);

    // Empty list: first pull is nil, ready again right after
    applyStimulus(1, 1, 0, 9, 1, 0);
    applyStimulus(1, 0, 1, 0, 0, 0);
    idle(2);

    // Stream running into the reserved all-ones value
    applyStimulus(1, 1, 0, 32'hFFFF_FFFC, 1, 10);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 1, 0, 0, 0);
    idle(1);

    // Negative step with sparse requests
    applyStimulus(1, 1, 0, 5, 32'hFFFF_FFFE, 3);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 1, 0, 0, 0);
      idle(3);
    end

    // Reset in the middle of a stream, then restart
    applyStimulus(1, 1, 0, 100, 10, 6);
    applyStimulus(1, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 40, 2, 2);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1, 0, 0, 0);

    // Arguments during RUN are ignored; request in accept cycle gives nothing
    applyStimulus(1, 1, 1, 20, 1, 3);
    applyStimulus(1, 1, 1, 500, 7, 9);
    applyStimulus(1, 1, 1, 600, 7, 9);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 0, 0, 0);
    idle(1);

    for (int i = 0; i < 600; i++) begin
      rn  = ($urandom_range(0, 63) != 0);
      av  = ($urandom_range(0, 3) == 0);
      req = ($urandom_range(0, 2) != 0);
      s   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 4) : $urandom;
      case ($urandom_range(0, 3))
        0:       st = 32'd1;
        1:       st = 32'hFFFF_FFFF;
        2:       st = 32'd0;
        default: st = $urandom;
      endcase
      c = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom_range(0, 6);
      applyStimulus(rn, av, req, s, st, c);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
